// File: rtl/coproc_result_arbiter.sv
// coproc_result_arbiter
//   Shares the single eXtension-interface result channel between NUM_UNITS
//   coprocessor functional units. A per-ID commit table records whether each
//   in-flight instruction was committed or killed by the core. Committed
//   results are forwarded through one registered output slot. Killed results
//   are accepted and dropped without reaching the core.
//
//   Build option: define COPROC_RESULT_ARB_FIXED_PRIO_EN to replace the
//   round-robin arbiter by fixed priority (lowest unit index wins, no rr
//   pointer). The default build (macro undefined) is round-robin.
module coproc_result_arbiter #(
  parameter int NUM_UNITS  = 2,
  parameter int X_ID_WIDTH = 4,
  parameter int XLEN       = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  // unit side
  input  logic [NUM_UNITS-1:0]            unit_valid_i,
  output logic [NUM_UNITS-1:0]            unit_ready_o,
  input  logic [NUM_UNITS*X_ID_WIDTH-1:0] unit_id_i,
  input  logic [NUM_UNITS*XLEN-1:0]       unit_data_i,
  input  logic [NUM_UNITS*5-1:0]          unit_rd_i,
  input  logic [NUM_UNITS-1:0]            unit_we_i,
  input  logic [NUM_UNITS-1:0]            unit_exc_i,
  input  logic [NUM_UNITS*6-1:0]          unit_exccode_i,
  // commit side
  input  logic                            commit_valid_i,
  input  logic [X_ID_WIDTH-1:0]           commit_id_i,
  input  logic                            commit_kill_i,
  // core result side
  output logic                            result_valid_o,
  input  logic                            result_ready_i,
  output logic [X_ID_WIDTH-1:0]           result_id_o,
  output logic [XLEN-1:0]                 result_data_o,
  output logic [4:0]                      result_rd_o,
  output logic                            result_we_o,
  output logic                            result_exc_o,
  output logic [5:0]                      result_exccode_o
);

  localparam int DEPTH = 2 ** X_ID_WIDTH;
  localparam int IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  localparam logic [1:0] ST_PENDING   = 2'b00;
  localparam logic [1:0] ST_COMMITTED = 2'b01;
  localparam logic [1:0] ST_KILLED    = 2'b10;

  // ------------------------------------------------------------------------
  // Commit table. Kept in flops rather than RAM: every unit needs its own
  // combinational lookup in the same cycle, and reset must clear all entries
  // at once.
  // ------------------------------------------------------------------------
  logic [1:0]            tbl_reg  [DEPTH];
  logic [1:0]            tbl_next [DEPTH];
  logic [DEPTH-1:0]      clr_mask;

  // Per-unit unpacked views of the flattened input buses
  logic [X_ID_WIDTH-1:0] u_id      [NUM_UNITS];
  logic [XLEN-1:0]       u_data    [NUM_UNITS];
  logic [4:0]            u_rd      [NUM_UNITS];
  logic [5:0]            u_exccode [NUM_UNITS];
  logic [1:0]            u_state   [NUM_UNITS];

  logic [NUM_UNITS-1:0]  drop_vec;
  logic [NUM_UNITS-1:0]  cand_vec;
  logic [NUM_UNITS-1:0]  grant_vec;
  logic [NUM_UNITS-1:0]  ready_int;
  logic [IDX_W-1:0]      grant_idx;
  logic                  grant_any;
  logic                  load_ok;

  // Output register
  logic                  out_valid_reg;
  logic [X_ID_WIDTH-1:0] out_id_reg;
  logic [XLEN-1:0]       out_data_reg;
  logic [4:0]            out_rd_reg;
  logic                  out_we_reg;
  logic                  out_exc_reg;
  logic [5:0]            out_exccode_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_UNITS; gi++) begin : g_unit
      assign u_id[gi]      = unit_id_i[gi*X_ID_WIDTH +: X_ID_WIDTH];
      assign u_data[gi]    = unit_data_i[gi*XLEN +: XLEN];
      assign u_rd[gi]      = unit_rd_i[gi*5 +: 5];
      assign u_exccode[gi] = unit_exccode_i[gi*6 +: 6];
      // Eligibility looks only at the registered table, so a commit shows up
      // one cycle after commit_valid_i.
      assign u_state[gi]   = tbl_reg[u_id[gi]];
      assign drop_vec[gi]  = unit_valid_i[gi] && (u_state[gi] == ST_KILLED);
      assign cand_vec[gi]  = unit_valid_i[gi] && (u_state[gi] == ST_COMMITTED);
    end
  endgenerate

  // The slot may load when empty, or when its current content leaves this cycle
  assign load_ok   = !out_valid_reg || result_ready_i;
  assign grant_any = (|cand_vec) && load_ok;

`ifdef COPROC_RESULT_ARB_FIXED_PRIO_EN

  // Fixed priority: lowest-index committed unit wins
  always_comb begin
    grant_idx = '0;
    for (int u = NUM_UNITS - 1; u >= 0; u--) begin
      if (cand_vec[u]) grant_idx = IDX_W'(u);
    end
  end

`else

  logic [IDX_W-1:0]     rr_reg;
  logic [IDX_W-1:0]     rr_next;
  logic [NUM_UNITS-1:0] hi_mask;
  logic [NUM_UNITS-1:0] cand_hi;

  // Round-robin: lowest candidate at or above rr_reg, else wrap to the lowest
  always_comb begin
    for (int u = 0; u < NUM_UNITS; u++) begin
      hi_mask[u] = (IDX_W'(u) >= rr_reg);
    end
    cand_hi   = cand_vec & hi_mask;
    grant_idx = '0;
    for (int u = NUM_UNITS - 1; u >= 0; u--) begin
      if (cand_vec[u]) grant_idx = IDX_W'(u);
    end
    for (int u = NUM_UNITS - 1; u >= 0; u--) begin
      if (cand_hi[u]) grant_idx = IDX_W'(u);
    end
    rr_next = (grant_idx == IDX_W'(NUM_UNITS - 1)) ? '0 : grant_idx + 1'b1;
  end

  // Advance the pointer past the unit that was just granted
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_reg <= '0;
    end else if (grant_any) begin
      rr_reg <= rr_next;
    end
  end

`endif

  // One-hot grant and combined per-unit acceptance (forwarded or dropped)
  always_comb begin
    grant_vec = '0;
    if (grant_any) grant_vec[grant_idx] = 1'b1;
    ready_int = drop_vec | grant_vec;
  end

  // Nothing is accepted while reset is asserted
  assign unit_ready_o = {NUM_UNITS{rst_ni}} & ready_int;

  // Table next-state: accepted IDs return to PENDING, a same-cycle commit wins
  always_comb begin
    clr_mask = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (ready_int[u]) clr_mask[u_id[u]] = 1'b1;
    end
    for (int i = 0; i < DEPTH; i++) begin
      tbl_next[i] = tbl_reg[i];
      if (commit_valid_i && (commit_id_i == X_ID_WIDTH'(i))) begin
        tbl_next[i] = commit_kill_i ? ST_KILLED : ST_COMMITTED;
      end else if (clr_mask[i]) begin
        tbl_next[i] = ST_PENDING;
      end
    end
  end

  // Commit table state
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) tbl_reg[i] <= ST_PENDING;
    end else begin
      for (int i = 0; i < DEPTH; i++) tbl_reg[i] <= tbl_next[i];
    end
  end

  // Output slot: load on grant, empty after handshake, hold under backpressure
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_valid_reg   <= 1'b0;
      out_id_reg      <= '0;
      out_data_reg    <= '0;
      out_rd_reg      <= '0;
      out_we_reg      <= 1'b0;
      out_exc_reg     <= 1'b0;
      out_exccode_reg <= '0;
    end else if (grant_any) begin
      out_valid_reg   <= 1'b1;
      out_id_reg      <= u_id[grant_idx];
      out_data_reg    <= u_data[grant_idx];
      out_rd_reg      <= u_rd[grant_idx];
      out_we_reg      <= unit_we_i[grant_idx];
      out_exc_reg     <= unit_exc_i[grant_idx];
      out_exccode_reg <= u_exccode[grant_idx];
    end else if (result_ready_i) begin
      out_valid_reg   <= 1'b0;
    end
  end

  assign result_valid_o   = out_valid_reg;
  assign result_id_o      = out_id_reg;
  assign result_data_o    = out_data_reg;
  assign result_rd_o      = out_rd_reg;
  assign result_we_o      = out_we_reg;
  assign result_exc_o     = out_exc_reg;
  assign result_exccode_o = out_exccode_reg;

endmodule

// File: tb/tb_coproc_result_arbiter.sv
// Directed testbench for coproc_result_arbiter (NUM_UNITS=2, X_ID_WIDTH=4, XLEN=32).
// Expectations follow the default round-robin build unless
// COPROC_RESULT_ARB_FIXED_PRIO_EN is defined.
module tb_coproc_result_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [1:0]  unit_valid_i;
  logic [1:0]  unit_ready_o;
  logic [7:0]  unit_id_i;
  logic [63:0] unit_data_i;
  logic [9:0]  unit_rd_i;
  logic [1:0]  unit_we_i;
  logic [1:0]  unit_exc_i;
  logic [11:0] unit_exccode_i;
  logic        commit_valid_i;
  logic [3:0]  commit_id_i;
  logic        commit_kill_i;
  logic        result_valid_o;
  logic        result_ready_i;
  logic [3:0]  result_id_o;
  logic [31:0] result_data_o;
  logic [4:0]  result_rd_o;
  logic        result_we_o;
  logic        result_exc_o;
  logic [5:0]  result_exccode_o;

  int n_checks = 0;
  int n_fail   = 0;

  coproc_result_arbiter #(
    .NUM_UNITS  (2),
    .X_ID_WIDTH (4),
    .XLEN       (32)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .unit_valid_i     (unit_valid_i),
    .unit_ready_o     (unit_ready_o),
    .unit_id_i        (unit_id_i),
    .unit_data_i      (unit_data_i),
    .unit_rd_i        (unit_rd_i),
    .unit_we_i        (unit_we_i),
    .unit_exc_i       (unit_exc_i),
    .unit_exccode_i   (unit_exccode_i),
    .commit_valid_i   (commit_valid_i),
    .commit_id_i      (commit_id_i),
    .commit_kill_i    (commit_kill_i),
    .result_valid_o   (result_valid_o),
    .result_ready_i   (result_ready_i),
    .result_id_o      (result_id_o),
    .result_data_o    (result_data_o),
    .result_rd_o      (result_rd_o),
    .result_we_o      (result_we_o),
    .result_exc_o     (result_exc_o),
    .result_exccode_o (result_exccode_o)
  );

  always #5 clk_i = ~clk_i;

  // One line per result handed to the core
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1 && result_valid_o === 1'b1 && result_ready_i === 1'b1)
      $display("xfer id=%0d data=%08h rd=%0d we=%0b exc=%0b code=%02h",
               result_id_o, result_data_o, result_rd_o, result_we_o,
               result_exc_o, result_exccode_o);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_u(input int u, input logic v, input logic [3:0] id,
                       input logic [31:0] d, input logic [4:0] rd, input logic we,
                       input logic exc, input logic [5:0] code);
    unit_valid_i[u]          = v;
    unit_id_i[u*4 +: 4]      = id;
    unit_data_i[u*32 +: 32]  = d;
    unit_rd_i[u*5 +: 5]      = rd;
    unit_we_i[u]             = we;
    unit_exc_i[u]            = exc;
    unit_exccode_i[u*6 +: 6] = code;
  endtask

  task automatic commit(input logic v, input logic [3:0] id, input logic k);
    commit_valid_i = v;
    commit_id_i    = id;
    commit_kill_i  = k;
  endtask

  // Round-robin scenario table (per cycle: valids, ids, expected ready, granted id)
  logic [1:0] t4_v   [4];
  logic [3:0] t4_id0 [4];
  logic [3:0] t4_id1 [4];
  logic [1:0] t4_rdy [4];
  logic [3:0] t4_res [4];

  initial begin
`ifdef COPROC_RESULT_ARB_FIXED_PRIO_EN
    t4_v   = '{2'b11, 2'b11, 2'b10, 2'b10};
    t4_id0 = '{4'd1,  4'd5,  4'd0,  4'd0};
    t4_id1 = '{4'd2,  4'd2,  4'd2,  4'd6};
    t4_rdy = '{2'b01, 2'b01, 2'b10, 2'b10};
    t4_res = '{4'd1,  4'd5,  4'd2,  4'd6};
`else
    // rr pointer is 1 here because unit 0 won the single-forward test
    t4_v   = '{2'b11, 2'b11, 2'b11, 2'b01};
    t4_id0 = '{4'd1,  4'd1,  4'd5,  4'd5};
    t4_id1 = '{4'd2,  4'd6,  4'd6,  4'd0};
    t4_rdy = '{2'b10, 2'b01, 2'b10, 2'b01};
    t4_res = '{4'd2,  4'd1,  4'd6,  4'd5};
`endif

    rst_ni = 1'b0;
    unit_valid_i = '0; unit_id_i = '0; unit_data_i = '0; unit_rd_i = '0;
    unit_we_i = '0; unit_exc_i = '0; unit_exccode_i = '0;
    commit(1'b0, 4'd0, 1'b0);
    result_ready_i = 1'b1;

    // ---- 1: reset with both units requesting
    set_u(0, 1'b1, 4'd0, 32'h11, 5'd1, 1'b1, 1'b0, 6'd0);
    set_u(1, 1'b1, 4'd1, 32'h22, 5'd2, 1'b1, 1'b0, 6'd0);
    step(); settle();
    chk("rst_valid", {63'd0, result_valid_o}, 64'd0);
    chk("rst_ready", {62'd0, unit_ready_o}, 64'd0);
    step(); settle();
    chk("rst_valid2", {63'd0, result_valid_o}, 64'd0);
    chk("rst_ready2", {62'd0, unit_ready_o}, 64'd0);
    chk("rst_data", {32'd0, result_data_o}, 64'd0);
    chk("rst_id", {60'd0, result_id_o}, 64'd0);
    rst_ni = 1'b1;
    settle();
    chk("post_rst_ready", {62'd0, unit_ready_o}, 64'd0);
    step(); settle();
    chk("post_rst_valid", {63'd0, result_valid_o}, 64'd0);
    chk("post_rst_ready2", {62'd0, unit_ready_o}, 64'd0);
    set_u(0, 1'b0, 4'd0, 32'h0, 5'd0, 1'b0, 1'b0, 6'd0);
    set_u(1, 1'b0, 4'd0, 32'h0, 5'd0, 1'b0, 1'b0, 6'd0);
    step();

    // ---- 2: single forward of id 3
    commit(1'b1, 4'd3, 1'b0);
    set_u(0, 1'b1, 4'd3, 32'hDEADBEEF, 5'd5, 1'b1, 1'b0, 6'd0);
    settle();
    chk("fwd_c0_ready", {62'd0, unit_ready_o}, 64'd0);
    step();
    commit(1'b0, 4'd0, 1'b0);
    settle();
    chk("fwd_c1_ready", {62'd0, unit_ready_o}, 64'h1);
    chk("fwd_c1_valid", {63'd0, result_valid_o}, 64'd0);
    step();
    set_u(0, 1'b0, 4'd0, 32'h0, 5'd0, 1'b0, 1'b0, 6'd0);
    settle();
    chk("fwd_c2_valid", {63'd0, result_valid_o}, 64'h1);
    chk("fwd_c2_id", {60'd0, result_id_o}, 64'h3);
    chk("fwd_c2_data", {32'd0, result_data_o}, 64'hDEADBEEF);
    chk("fwd_c2_rd", {59'd0, result_rd_o}, 64'h5);
    chk("fwd_c2_we", {63'd0, result_we_o}, 64'h1);
    chk("fwd_c2_exc", {63'd0, result_exc_o}, 64'h0);
    step(); settle();
    chk("fwd_c3_valid", {63'd0, result_valid_o}, 64'd0);

    // ---- 3: killed id 7 on unit 1 is dropped
    commit(1'b1, 4'd7, 1'b1);
    set_u(1, 1'b1, 4'd7, 32'h77, 5'd7, 1'b1, 1'b0, 6'd0);
    settle();
    chk("kill_c0_ready", {62'd0, unit_ready_o}, 64'd0);
    step();
    commit(1'b0, 4'd0, 1'b0);
    settle();
    chk("kill_c1_ready", {62'd0, unit_ready_o}, 64'h2);
    step(); settle();
    chk("kill_c2_ready_pending", {62'd0, unit_ready_o}, 64'd0);
    chk("kill_c2_valid", {63'd0, result_valid_o}, 64'd0);
    set_u(1, 1'b0, 4'd0, 32'h0, 5'd0, 1'b0, 1'b0, 6'd0);
    step(); settle();
    chk("kill_c3_valid", {63'd0, result_valid_o}, 64'd0);

    // ---- 4: arbitration with fresh committed ids
    commit(1'b1, 4'd1, 1'b0); step();
    commit(1'b1, 4'd2, 1'b0); step();
    commit(1'b1, 4'd5, 1'b0); step();
    commit(1'b1, 4'd6, 1'b0); step();
    commit(1'b0, 4'd0, 1'b0);
    for (int r = 0; r < 4; r++) begin
      set_u(0, t4_v[r][0], t4_id0[r], {28'd0, t4_id0[r]}, 5'd10, 1'b1, 1'b0, 6'd0);
      set_u(1, t4_v[r][1], t4_id1[r], {28'd0, t4_id1[r]}, 5'd11, 1'b1, 1'b0, 6'd0);
      settle();
      chk($sformatf("arb_ready_%0d", r), {62'd0, unit_ready_o}, {62'd0, t4_rdy[r]});
      if (r > 0) begin
        chk($sformatf("arb_valid_%0d", r), {63'd0, result_valid_o}, 64'h1);
        chk($sformatf("arb_id_%0d", r), {60'd0, result_id_o}, {60'd0, t4_res[r-1]});
      end
      step();
    end
    set_u(0, 1'b0, 4'd0, 32'h0, 5'd0, 1'b0, 1'b0, 6'd0);
    set_u(1, 1'b0, 4'd0, 32'h0, 5'd0, 1'b0, 1'b0, 6'd0);
    settle();
    chk("arb_last_valid", {63'd0, result_valid_o}, 64'h1);
    chk("arb_last_id", {60'd0, result_id_o}, {60'd0, t4_res[3]});
    chk("arb_last_data", {32'd0, result_data_o}, {60'd0, t4_res[3]});
    step(); settle();
    chk("arb_drain_valid", {63'd0, result_valid_o}, 64'd0);

    // ---- 5: backpressure, with a drop while the slot is full
    commit(1'b1, 4'd8, 1'b0); step();
    commit(1'b1, 4'd9, 1'b0); step();
    commit(1'b1, 4'd10, 1'b1); step();
    commit(1'b0, 4'd0, 1'b0);
    result_ready_i = 1'b0;
    set_u(0, 1'b1, 4'd8, 32'hAAAA0008, 5'd1, 1'b1, 1'b0, 6'd0);
    settle();
    chk("bp_grant_empty", {62'd0, unit_ready_o}, 64'h1);
    step();
    set_u(0, 1'b1, 4'd9, 32'hBBBB0009, 5'd2, 1'b1, 1'b0, 6'd0);
    for (int i = 0; i < 4; i++) begin
      set_u(1, (i == 1), 4'd10, 32'hCC, 5'd3, 1'b1, 1'b0, 6'd0);
      settle();
      chk($sformatf("bp_ready_%0d", i), {62'd0, unit_ready_o}, (i == 1) ? 64'h2 : 64'h0);
      chk($sformatf("bp_valid_%0d", i), {63'd0, result_valid_o}, 64'h1);
      chk($sformatf("bp_id_%0d", i), {60'd0, result_id_o}, 64'h8);
      chk($sformatf("bp_data_%0d", i), {32'd0, result_data_o}, 64'hAAAA0008);
      step();
    end
    set_u(1, 1'b0, 4'd0, 32'h0, 5'd0, 1'b0, 1'b0, 6'd0);
    result_ready_i = 1'b1;
    settle();
    chk("bp_release_ready", {62'd0, unit_ready_o}, 64'h1);
    chk("bp_release_id", {60'd0, result_id_o}, 64'h8);
    step();
    set_u(0, 1'b0, 4'd0, 32'h0, 5'd0, 1'b0, 1'b0, 6'd0);
    settle();
    chk("bp_next_valid", {63'd0, result_valid_o}, 64'h1);
    chk("bp_next_id", {60'd0, result_id_o}, 64'h9);
    chk("bp_next_data", {32'd0, result_data_o}, 64'hBBBB0009);
    chk("bp_next_rd", {59'd0, result_rd_o}, 64'h2);
    step(); settle();
    chk("bp_empty", {63'd0, result_valid_o}, 64'd0);

    // ---- 6: commit of id 4 collides with its own clear
    commit(1'b1, 4'd4, 1'b0); step();
    set_u(0, 1'b1, 4'd4, 32'h44, 5'd3, 1'b0, 1'b1, 6'h0D);
    commit(1'b1, 4'd4, 1'b0);
    settle();
    chk("coll_ready0", {62'd0, unit_ready_o}, 64'h1);
    step();
    commit(1'b0, 4'd0, 1'b0);
    settle();
    chk("coll_ready_again", {62'd0, unit_ready_o}, 64'h1);
    chk("coll_valid", {63'd0, result_valid_o}, 64'h1);
    chk("coll_id", {60'd0, result_id_o}, 64'h4);
    chk("coll_we", {63'd0, result_we_o}, 64'h0);
    chk("coll_exc", {63'd0, result_exc_o}, 64'h1);
    chk("coll_exccode", {58'd0, result_exccode_o}, 64'h0D);
    step(); settle();
    chk("coll_cleared_ready", {62'd0, unit_ready_o}, 64'd0);
    chk("coll_valid2", {63'd0, result_valid_o}, 64'h1);
    set_u(0, 1'b0, 4'd0, 32'h0, 5'd0, 1'b0, 1'b0, 6'd0);
    step(); settle();
    chk("coll_empty", {63'd0, result_valid_o}, 64'd0);

    // ---- mid-operation reset discards a buffered result and the table
    commit(1'b1, 4'd11, 1'b0); step();
    commit(1'b0, 4'd0, 1'b0);
    result_ready_i = 1'b0;
    set_u(0, 1'b1, 4'd11, 32'h1111, 5'd4, 1'b1, 1'b0, 6'd0);
    settle();
    chk("mrst_grant", {62'd0, unit_ready_o}, 64'h1);
    step(); settle();
    chk("mrst_held", {63'd0, result_valid_o}, 64'h1);
    commit(1'b1, 4'd11, 1'b0);
    rst_ni = 1'b0;
    settle();
    chk("mrst_ready_in_reset", {62'd0, unit_ready_o}, 64'd0);
    step(); settle();
    chk("mrst_valid", {63'd0, result_valid_o}, 64'd0);
    chk("mrst_data", {32'd0, result_data_o}, 64'd0);
    commit(1'b0, 4'd0, 1'b0);
    rst_ni = 1'b1;
    settle();
    chk("mrst_table_pending", {62'd0, unit_ready_o}, 64'd0);
    step(); settle();
    chk("mrst_valid_after", {63'd0, result_valid_o}, 64'd0);
    set_u(0, 1'b0, 4'd0, 32'h0, 5'd0, 1'b0, 1'b0, 6'd0);
    result_ready_i = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
